// File: rtl/mem_pkg.sv
// Shared widths, FSM encoding and buffer entry type for the memory write buffer.
// Pure declarations: no logic, no latency, no flow control.
package mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    RD_MEM = 2'd2,
    RESP   = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/mem_write_buffer_if.sv
// Cache-side request/response and backing-RAM handshake bundle for mem_write_buffer.
// master = cache + RAM model side, slave = the buffer itself.
interface mem_write_buffer_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  count;

  modport master (
    output req_valid, req_rw, req_addr, req_data, mem_ack, mem_rdata,
    input  req_ready, rd_valid, rd_data, mem_req, mem_rw, mem_addr, mem_wdata, count
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, mem_ack, mem_rdata,
    output req_ready, rd_valid, rd_data, mem_req, mem_rw, mem_addr, mem_wdata, count
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular write-entry store with head/count tracking; push/pop take effect on the next edge.
// No internal backpressure: caller must not push when full or pop when empty. WB_FORWARD_EN adds the youngest-match search.
module wb_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
`ifdef WB_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      store_q[wr_ptr_q] <= '{addr: push_addr_i, data: push_data_i};
    end
  end

  assign head_addr_o = store_q[rd_ptr_q].addr;
  assign head_data_o = store_q[rd_ptr_q].data;
  assign count_o     = count_q;
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] idx;

  // Scan oldest to youngest so the last hit is the most recent write.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (store_q[idx].addr == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = store_q[idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer in front of a single-port RAM: writes retire immediately, drains one entry per RAM handshake, one read outstanding.
// Reads stall while entries are pending; with WB_FORWARD_EN defined they are served from the buffer or bypass pending drains.
module mem_write_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               clr,
  mem_write_buffer_if.slave  bus
);

  wb_state_e         state_q;
  logic              mem_req_q;
  logic              mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              req_ready;
  logic              wr_acc;
  logic              rd_acc;
  logic              pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  assign wr_acc = bus.req_valid && req_ready && bus.req_rw;
  assign rd_acc = bus.req_valid && req_ready && !bus.req_rw;
  assign pop    = (state_q == DRAIN) && mem_req_q && bus.mem_ack;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .clr         (clr),
    .push_i      (wr_acc),
    .push_addr_i (bus.req_addr),
    .push_data_i (bus.req_data),
    .pop_i       (pop),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
`ifdef WB_FORWARD_EN
    ,
    .lookup_addr_i (bus.req_addr),
    .hit_o         (fwd_hit),
    .hit_data_o    (fwd_data)
`endif
  );

`ifndef WB_FORWARD_EN
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // Writes may land while a drain is in flight; reads only start from IDLE.
  always_comb begin
    req_ready = 1'b0;
    if (bus.req_rw) begin
      req_ready = ((state_q == IDLE) || (state_q == DRAIN)) && !full;
    end else begin
`ifdef WB_FORWARD_EN
      req_ready = (state_q == IDLE);
`else
      req_ready = (state_q == IDLE) && empty;
`endif
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_acc) begin
            if (fwd_hit) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= fwd_data;
              state_q    <= RESP;
            end else begin
              mem_req_q  <= 1'b1;
              mem_rw_q   <= 1'b0;
              mem_addr_q <= bus.req_addr;
              state_q    <= RD_MEM;
            end
          end else if (!empty) begin
            mem_req_q   <= 1'b1;
            mem_rw_q    <= 1'b1;
            mem_addr_q  <= head_addr;
            mem_wdata_q <= head_data;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        RD_MEM: begin
          if (bus.mem_ack) begin
            mem_req_q  <= 1'b0;
            rd_valid_q <= 1'b1;
            rd_data_q  <= bus.mem_rdata;
            state_q    <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.count     = count;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed + randomized bench for mem_write_buffer; reference is a write queue plus a 256-byte RAM image.
// Honours WB_FORWARD_EN the same way the design does.
module tb_mem_write_buffer;

  localparam int DEPTH = 4;
  localparam int TMO   = 200;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk;
  logic clr;
  logic auto_en = 1'b0;
  logic auto_ack_r = 1'b0;
  logic man_ack_r = 1'b0;
  logic [7:0] rdata_r = 8'h00;
  int fixed_dly = -1;
  logic [7:0] mem_arr [256];
  logic [7:0] rd_addr_exp = 8'h00;
  wr_t wq [$];
  int n_checks = 0;
  int n_err = 0;
  int n_mem_rd = 0;

  mem_write_buffer_if bus ();

  mem_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  assign bus.mem_ack   = auto_ack_r | man_ack_r;
  assign bus.mem_rdata = rdata_r;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The write the RAM is completing must be the oldest one the model holds.
  task automatic drain_check();
    wr_t e;
    chk("drain_has_entry", 32'(wq.size() > 0), 1);
    if (wq.size() > 0) begin
      e = wq.pop_front();
      chk("drain_addr", bus.mem_addr, e.a);
      chk("drain_data", bus.mem_wdata, e.d);
      mem_arr[e.a] = e.d;
    end
  endtask

  initial begin : ram_model
    int wait_n;
    int dly;
    wait_n = 0;
    dly = 0;
    forever begin
      @(negedge clk);
      if (!auto_en || auto_ack_r) begin
        auto_ack_r = 1'b0;
        wait_n = 0;
      end else if (bus.mem_req) begin
        if (wait_n == 0) dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
        if (wait_n >= dly) begin
          auto_ack_r = 1'b1;
          if (bus.mem_rw) begin
            drain_check();
          end else begin
            chk("rd_mem_addr", bus.mem_addr, rd_addr_exp);
            rdata_r = mem_arr[bus.mem_addr];
            n_mem_rd++;
          end
        end else begin
          wait_n++;
        end
      end
    end
  end

  task automatic idle_req();
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_data  = 8'h00;
  endtask

  task automatic manual_ack();
    chk("mack_mem_req", bus.mem_req, 1);
    drain_check();
    man_ack_r = 1'b1;
    @(negedge clk);
    man_ack_r = 1'b0;
  endtask

  // Leaves the request driven so consecutive calls are back to back.
  task automatic write_req(input logic [7:0] a, input logic [7:0] d);
    int t;
    logic done;
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    t = 0;
    done = 1'b0;
    while (!done && t < TMO) begin
      #1;
      if (bus.req_ready) begin
        wq.push_back('{a, d});
        done = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    chk("wr_accept", done, 1);
  endtask

  task automatic read_req(input logic [7:0] a);
    int t;
    int cyc;
    int rd_before;
    logic done;
    logic hit;
    logic [7:0] exp;
    bus.req_valid = 1'b1;
    bus.req_rw    = 1'b0;
    bus.req_addr  = a;
    bus.req_data  = 8'h00;
    rd_addr_exp   = a;
    t = 0;
    done = 1'b0;
    hit = 1'b0;
    exp = 8'h00;
    rd_before = 0;
    while (!done && t < TMO) begin
      #1;
      if (bus.req_ready) begin
        done = 1'b1;
        exp = mem_arr[a];
        foreach (wq[i]) begin
          if (wq[i].a == a) begin
            exp = wq[i].d;
            hit = 1'b1;
          end
        end
`ifndef WB_FORWARD_EN
        chk("rd_after_drain", bus.count, 0);
`endif
        rd_before = n_mem_rd;
      end
      @(negedge clk);
      t++;
    end
    chk("rd_accept", done, 1);
    idle_req();
    cyc = 1;
    while (!bus.rd_valid && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    chk("rd_valid", bus.rd_valid, 1);
    chk("rd_data", bus.rd_data, exp);
    if (hit) begin
      chk("fwd_latency", cyc, 1);
      chk("fwd_no_mem_read", n_mem_rd, rd_before);
    end
    @(negedge clk);
    chk("rd_pulse_1cyc", bus.rd_valid, 0);
  endtask

  task automatic wait_drained();
    int t;
    t = 0;
    while ((bus.count != 0 || bus.mem_req) && t < 4 * TMO) begin
      @(negedge clk);
      t++;
    end
    chk("drained_count", bus.count, 0);
    chk("drained_model", wq.size(), 0);
  endtask

  initial begin : stim
    int t;
    logic [7:0] a;
    logic [7:0] d;

    clr = 1'b1;
    idle_req();
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i) ^ 8'h5A;

    // Reset state
    @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_rw", bus.mem_rw, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    clr = 1'b0;

    // Single write drained with a delayed ack
    auto_en = 1'b1;
    fixed_dly = 2;
    write_req(8'h01, 8'hE0);
    idle_req();
    chk("w1_count", bus.count, 1);
    t = 0;
    while (!bus.mem_req && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk("w1_mem_req", bus.mem_req, 1);
    chk("w1_mem_rw", bus.mem_rw, 1);
    chk("w1_mem_addr", bus.mem_addr, 8'h01);
    chk("w1_mem_wdata", bus.mem_wdata, 8'hE0);
    wait_drained();

    // Fill to DEPTH with ack held low, then one ack frees a slot
    auto_en = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) write_req(8'(i), 8'h10 + 8'(i));
    bus.req_addr = 8'h05;
    bus.req_data = 8'h15;
    #1;
    chk("full_req_ready", bus.req_ready, 0);
    chk("full_count", bus.count, DEPTH);
    @(negedge clk);
    chk("full_held_mem_addr", bus.mem_addr, 8'h01);
    manual_ack();
    write_req(8'h05, 8'h15);
    idle_req();
    chk("refill_count", bus.count, 4);
    auto_en = 1'b1;
    fixed_dly = -1;
    wait_drained();

    // Push and pop in the same cycle at count 2
    auto_en = 1'b0;
    @(negedge clk);
    write_req(8'h21, 8'hA1);
    write_req(8'h22, 8'hA2);
    bus.req_addr = 8'h23;
    bus.req_data = 8'hA3;
    chk("simul_pre_count", bus.count, 2);
    drain_check();
    man_ack_r = 1'b1;
    #1;
    chk("simul_req_ready", bus.req_ready, 1);
    wq.push_back('{8'h23, 8'hA3});
    @(negedge clk);
    man_ack_r = 1'b0;
    idle_req();
    chk("simul_count", bus.count, 2);

    // Ten writes through the wrapping pointers; order checked at each drain
    auto_en = 1'b1;
    for (int i = 0; i < 10; i++) write_req(8'h30 + 8'(i), 8'($urandom));
    idle_req();
    wait_drained();

    // Two writes to one address followed by a read of it
    fixed_dly = 3;
    write_req(8'h02, 8'hC0);
    write_req(8'h02, 8'hC7);
    read_req(8'h02);
    chk("vec_rd_data", bus.rd_data, 8'hC7);
    fixed_dly = -1;
    wait_drained();

    // Reset in the middle of a drain with three entries pending
    auto_en = 1'b0;
    @(negedge clk);
    write_req(8'h41, 8'hB1);
    write_req(8'h42, 8'hB2);
    write_req(8'h43, 8'hB3);
    idle_req();
    chk("clr_pre_count", bus.count, 3);
    chk("clr_pre_mem_req", bus.mem_req, 1);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_count", bus.count, 0);
    chk("clr_mem_req", bus.mem_req, 0);
    chk("clr_req_ready", bus.req_ready, 1);
    wq.delete();
    @(negedge clk);
    clr = 1'b0;
    man_ack_r = 1'b1;
    @(negedge clk);
    man_ack_r = 1'b0;
    chk("stale_ack_count", bus.count, 0);
    chk("stale_ack_mem_req", bus.mem_req, 0);
    chk("stale_ack_rd_valid", bus.rd_valid, 0);
    @(negedge clk);
    chk("stale_ack_mem_req2", bus.mem_req, 0);

    // Randomized mix on a small address window to provoke matches
    auto_en = 1'b1;
    fixed_dly = -1;
    for (int n = 0; n < 150; n++) begin
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      if ($urandom_range(0, 2) != 0) write_req(a, d);
      else read_req(a);
      if ($urandom_range(0, 1) == 1) begin
        idle_req();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    idle_req();
    wait_drained();

    // Read on an empty buffer goes straight to memory
    read_req(8'h03);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
